// File: rtl/proc_imm_pkg.sv
// rtl/proc_imm_pkg.sv - immediate types and instruction field positions for the immediate generator
package proc_imm_pkg;

    typedef enum logic [2:0] {
        IMM_I     = 3'd0,
        IMM_S     = 3'd1,
        IMM_B     = 3'd2,
        IMM_U     = 3'd3,
        IMM_J     = 3'd4,
        IMM_CSR   = 3'd5,
        IMM_SHAMT = 3'd6,
        IMM_ILL   = 3'd7
    } imm_type_t;

    localparam int SIGN_BIT   = 31;
    localparam int I_LO       = 20;
    localparam int S_HI_LO    = 25;
    localparam int S_LO_HI    = 11;
    localparam int S_LO_LO    = 7;
    localparam int B_B11      = 7;
    localparam int B_LO_LO    = 8;
    localparam int U_LO       = 12;
    localparam int J_HI_HI    = 19;
    localparam int J_HI_LO    = 12;
    localparam int J_B11      = 20;
    localparam int J_LO_HI    = 30;
    localparam int J_LO_LO    = 21;
    localparam int CSR_HI     = 19;
    localparam int CSR_LO     = 15;
    localparam int SH_HI_32   = 24;
    localparam int SH_HI_64   = 25;
    localparam int SH_LO      = 20;

endpackage

// File: rtl/proc_imm_decode.sv
// rtl/proc_imm_decode.sv - combinational type-to-immediate extraction
module proc_imm_decode
    import proc_imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    input  logic [2:0]      imm_type,
    output logic [XLEN-1:0] imm,
    output logic            err
);

    // Every format fits a signed 32-bit value; widening to XLEN is a plain
    // sign extension (CSR/SHAMT keep bit 31 clear, so they zero-extend).
    logic [31:0] v32;
    logic        s;

    // Opcode bits are never part of any immediate.
    logic unused_opcode;
    assign unused_opcode = ^inst[6:0];

    assign s = inst[SIGN_BIT];

    // Select the immediate layout for the requested type; illegal gives 0 with err.
    always_comb begin
        v32 = '0;
        err = 1'b0;
        case (imm_type_t'(imm_type))
            IMM_I:     v32 = {{21{s}}, inst[30:I_LO]};
            IMM_S:     v32 = {{21{s}}, inst[30:S_HI_LO], inst[S_LO_HI:S_LO_LO]};
            IMM_B:     v32 = {{20{s}}, inst[B_B11], inst[30:S_HI_LO], inst[S_LO_HI:B_LO_LO], 1'b0};
            IMM_U:     v32 = {inst[SIGN_BIT:U_LO], 12'b0};
            IMM_J:     v32 = {{12{s}}, inst[J_HI_HI:J_HI_LO], inst[J_B11], inst[J_LO_HI:J_LO_LO], 1'b0};
            IMM_CSR:   v32 = {27'b0, inst[CSR_HI:CSR_LO]};
            IMM_SHAMT: begin
                if (XLEN == 64) begin
                    v32 = {26'b0, inst[SH_HI_64:SH_LO]};
                end else begin
                    v32 = {27'b0, inst[SH_HI_32:SH_LO]};
                end
            end
            default:   err = 1'b1;
        endcase
    end

    assign imm = XLEN'($signed(v32));

endmodule

// File: rtl/proc_dpath_imm_gen_pipe.sv
// rtl/proc_dpath_imm_gen_pipe.sv - registered immediate generator with val/rdy; PROC_IMM_GEN_SKID_EN selects a 2-entry skid buffer
module proc_dpath_imm_gen_pipe
    import proc_imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             squash,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [31:0]      in_inst,
    input  logic [2:0]       in_type,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_err,
    output logic [TAG_W-1:0] out_tag
);

    logic [XLEN-1:0] dec_imm;
    logic            dec_err;
    logic            accept;
    logic            retire;

    proc_imm_decode #(.XLEN(XLEN)) u_decode (
        .inst     (in_inst),
        .imm_type (in_type),
        .imm      (dec_imm),
        .err      (dec_err)
    );

    // Slot 0 is the head entry and drives the outputs directly.
    logic             val0_q, val0_d;
    logic [XLEN-1:0]  imm0_q, imm0_d;
    logic             err0_q, err0_d;
    logic [TAG_W-1:0] tag0_q, tag0_d;

    assign retire = val0_q & out_rdy;
    assign accept = in_val & in_rdy;

`ifdef PROC_IMM_GEN_SKID_EN
    logic             val1_q, val1_d;
    logic [XLEN-1:0]  imm1_q, imm1_d;
    logic             err1_q, err1_d;
    logic [TAG_W-1:0] tag1_q, tag1_d;

    // Ready depends only on the tail slot register, never on out_rdy.
    assign in_rdy = reset & ~squash & ~val1_q;

    // Two-slot FIFO: retire shifts the tail forward, accept fills the first free slot.
    always_comb begin
        val0_d = val0_q;
        imm0_d = imm0_q;
        err0_d = err0_q;
        tag0_d = tag0_q;
        val1_d = val1_q;
        imm1_d = imm1_q;
        err1_d = err1_q;
        tag1_d = tag1_q;
        if (squash) begin
            val0_d = 1'b0;
            val1_d = 1'b0;
        end else begin
            if (retire) begin
                val0_d = val1_q;
                val1_d = 1'b0;
                if (val1_q) begin
                    imm0_d = imm1_q;
                    err0_d = err1_q;
                    tag0_d = tag1_q;
                end
            end
            if (accept) begin
                if (!val0_d) begin
                    val0_d = 1'b1;
                    imm0_d = dec_imm;
                    err0_d = dec_err;
                    tag0_d = in_tag;
                end else begin
                    val1_d = 1'b1;
                    imm1_d = dec_imm;
                    err1_d = dec_err;
                    tag1_d = in_tag;
                end
            end
        end
    end

    // Tail slot storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            val1_q <= 1'b0;
            imm1_q <= '0;
            err1_q <= 1'b0;
            tag1_q <= '0;
        end else begin
            val1_q <= val1_d;
            imm1_q <= imm1_d;
            err1_q <= err1_d;
            tag1_q <= tag1_d;
        end
    end
`else
    // Pass-through ready: a full register can still accept when it retires this cycle.
    assign in_rdy = reset & ~squash & (~val0_q | out_rdy);

    // Single pipeline register: squash wins, then accept (covers retire+accept), then retire.
    always_comb begin
        val0_d = val0_q;
        imm0_d = imm0_q;
        err0_d = err0_q;
        tag0_d = tag0_q;
        if (squash) begin
            val0_d = 1'b0;
        end else if (accept) begin
            val0_d = 1'b1;
            imm0_d = dec_imm;
            err0_d = dec_err;
            tag0_d = in_tag;
        end else if (retire) begin
            val0_d = 1'b0;
        end
    end
`endif

    // Head slot storage; data is held when empty or stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            val0_q <= 1'b0;
            imm0_q <= '0;
            err0_q <= 1'b0;
            tag0_q <= '0;
        end else begin
            val0_q <= val0_d;
            imm0_q <= imm0_d;
            err0_q <= err0_d;
            tag0_q <= tag0_d;
        end
    end

    assign out_val = val0_q;
    assign out_imm = imm0_q;
    assign out_err = err0_q;
    assign out_tag = tag0_q;

endmodule

// File: tb/tb_proc_dpath_imm_gen_pipe.sv
// tb/tb_proc_dpath_imm_gen_pipe.sv - scoreboard bench for the immediate generator, XLEN 32 and 64 side by side
module tb_proc_dpath_imm_gen_pipe;

`ifdef PROC_IMM_GEN_SKID_EN
    localparam int BP_ACC = 2;
`else
    localparam int BP_ACC = 1;
`endif

    logic        clk = 1'b0;
    logic        reset, squash, in_val, out_rdy;
    logic [31:0] in_inst;
    logic [2:0]  in_type;
    logic [3:0]  in_tag;
    logic        rdy32, rdy64, ov32, ov64, oe32, oe64;
    logic [31:0] oi32;
    logic [63:0] oi64;
    logic [3:0]  ot32, ot64;

    always #5 clk = ~clk;

    proc_dpath_imm_gen_pipe #(.XLEN(32), .TAG_W(4)) dut32 (
        .clk(clk), .reset(reset), .squash(squash), .in_val(in_val), .in_rdy(rdy32),
        .in_inst(in_inst), .in_type(in_type), .in_tag(in_tag), .out_val(ov32),
        .out_rdy(out_rdy), .out_imm(oi32), .out_err(oe32), .out_tag(ot32)
    );

    proc_dpath_imm_gen_pipe #(.XLEN(64), .TAG_W(4)) dut64 (
        .clk(clk), .reset(reset), .squash(squash), .in_val(in_val), .in_rdy(rdy64),
        .in_inst(in_inst), .in_type(in_type), .in_tag(in_tag), .out_val(ov64),
        .out_rdy(out_rdy), .out_imm(oi64), .out_err(oe64), .out_tag(ot64)
    );

    typedef struct packed {
        logic [63:0] imm;
        logic        err;
        logic [3:0]  tag;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];
    int   checks = 0;
    int   errors = 0;

    logic        hold_v = 1'b0;
    logic [31:0] h_imm32;
    logic [63:0] h_imm64;
    logic [3:0]  h_tag32;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference immediate computed arithmetically from the instruction fields.
    function automatic logic [63:0] model(input logic [31:0] inst, input logic [2:0] t, input int xlen);
        int     si;
        longint sl;
        longint v;
        si = int'(inst);
        sl = si;
        case (t)
            3'd0: v = sl >>> 20;
            3'd1: v = (sl >>> 25) * 32 + longint'(inst[11:7]);
            3'd2: v = (sl >>> 31) * 4096 + longint'(inst[7]) * 2048
                      + longint'(inst[30:25]) * 32 + longint'(inst[11:8]) * 2;
            3'd3: v = longint'(int'(inst & 32'hFFFFF000));
            3'd4: v = (sl >>> 31) * 1048576 + longint'(inst[19:12]) * 4096
                      + longint'(inst[20]) * 2048 + longint'(inst[30:21]) * 2;
            3'd5: v = longint'(inst[19:15]);
            3'd6: v = (xlen == 64) ? longint'(inst[25:20]) : longint'(inst[24:20]);
            default: v = 0;
        endcase
        if (xlen == 32) return {32'b0, v[31:0]};
        return v;
    endfunction

    // Monitor: retire/compare and record accepts, all sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!reset || squash) begin
            q32.delete();
            q64.delete();
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("hold_val32", {63'b0, ov32}, 64'd1);
                chk("hold_imm32", {32'b0, oi32}, {32'b0, h_imm32});
                chk("hold_imm64", oi64, h_imm64);
                chk("hold_tag32", {60'b0, ot32}, {60'b0, h_tag32});
            end
            hold_v  = ov32 && !out_rdy;
            h_imm32 = oi32;
            h_imm64 = oi64;
            h_tag32 = ot32;
            if (ov32 && out_rdy) begin
                if (q32.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL out32_unexpected actual=tag %0d required=no output", ot32);
                end else begin
                    e = q32.pop_front();
                    chk("imm32", {32'b0, oi32}, e.imm);
                    chk("err32", {63'b0, oe32}, {63'b0, e.err});
                    chk("tag32", {60'b0, ot32}, {60'b0, e.tag});
                end
            end
            if (ov64 && out_rdy) begin
                if (q64.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL out64_unexpected actual=tag %0d required=no output", ot64);
                end else begin
                    e = q64.pop_front();
                    chk("imm64", oi64, e.imm);
                    chk("err64", {63'b0, oe64}, {63'b0, e.err});
                    chk("tag64", {60'b0, ot64}, {60'b0, e.tag});
                end
            end
            if (in_val && rdy32) begin
                e.imm = model(in_inst, in_type, 32);
                e.err = (in_type == 3'd7);
                e.tag = in_tag;
                q32.push_back(e);
            end
            if (in_val && rdy64) begin
                e.imm = model(in_inst, in_type, 64);
                e.err = (in_type == 3'd7);
                e.tag = in_tag;
                q64.push_back(e);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send1(input string name, input logic [31:0] inst, input logic [2:0] t,
                         input logic [3:0] tag, input logic [31:0] e32, input logic [63:0] e64,
                         input logic eerr);
        in_inst = inst;
        in_type = t;
        in_tag  = tag;
        in_val  = 1'b1;
        cyc();
        in_val  = 1'b0;
        chk({name, "_val"}, {63'b0, ov32}, 64'd1);
        chk({name, "_imm32"}, {32'b0, oi32}, {32'b0, e32});
        chk({name, "_imm64"}, oi64, e64);
        chk({name, "_err"}, {62'b0, oe64, oe32}, {62'b0, eerr, eerr});
        chk({name, "_tag"}, {60'b0, ot64}, {60'b0, tag});
        cyc();
    endtask

    initial begin
        int acc;
        int nxt;
        int guard;
        reset   = 1'b1;
        squash  = 1'b0;
        in_val  = 1'b0;
        out_rdy = 1'b0;
        in_inst = '0;
        in_type = '0;
        in_tag  = '0;
        #1 reset = 1'b0;
        #2;
        chk("rst_out_val", {62'b0, ov64, ov32}, 64'd0);
        chk("rst_out_imm", oi64 | {32'b0, oi32}, 64'd0);
        chk("rst_out_err", {62'b0, oe64, oe32}, 64'd0);
        chk("rst_out_tag", {56'b0, ot64, ot32}, 64'd0);
        chk("rst_in_rdy", {62'b0, rdy64, rdy32}, 64'd0);
        repeat (2) cyc();
        reset   = 1'b1;
        out_rdy = 1'b1;
        cyc();

        send1("i_neg1", 32'hFFF00093, 3'd0, 4'd1, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        send1("s_neg1", 32'hFE000FA3, 3'd1, 4'd2, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        send1("b_neg4", 32'hFE000EE3, 3'd2, 4'd3, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        send1("u_pos", 32'h123450B7, 3'd3, 4'd4, 32'h12345000, 64'h0000000012345000, 1'b0);
        send1("u_neg", 32'h800000B7, 3'd3, 4'd5, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0);
        send1("csr31", 32'h000F8000, 3'd5, 4'd6, 32'h0000001F, 64'h000000000000001F, 1'b0);
        send1("shamt", 32'h03F00000, 3'd6, 4'd7, 32'h0000001F, 64'h000000000000003F, 1'b0);
        send1("ill", 32'hFFFFFFFF, 3'd7, 4'd8, 32'h00000000, 64'h0000000000000000, 1'b1);

        // Backpressure: offer tags 1,2,3 while the consumer stalls.
        out_rdy = 1'b0;
        acc = 0;
        nxt = 1;
        repeat (3) begin
            in_val  = 1'b1;
            in_tag  = 4'(nxt);
            in_type = 3'd0;
            in_inst = $urandom;
            @(negedge clk);
            if (rdy32) begin
                acc++;
                nxt++;
            end
            cyc();
        end
        chk("bp_accepted", 64'(acc), 64'(BP_ACC));
        chk("bp_in_rdy", {62'b0, rdy64, rdy32}, 64'd0);
        chk("bp_head_tag", {60'b0, ot32}, 64'd1);
        out_rdy = 1'b1;
        guard = 0;
        while (nxt <= 3 && guard < 20) begin
            in_tag  = 4'(nxt);
            in_inst = $urandom;
            @(negedge clk);
            if (rdy32) nxt++;
            cyc();
            guard++;
        end
        in_val = 1'b0;
        chk("bp_all_offered", 64'(nxt), 64'd4);
        repeat (4) cyc();
        chk("bp_drain32", 64'(q32.size()), 64'd0);

        // Squash while full with an entry on offer.
        out_rdy = 1'b0;
        in_val  = 1'b1;
        repeat (3) begin
            in_inst = $urandom;
            in_type = 3'($urandom_range(0, 7));
            in_tag  = 4'($urandom);
            cyc();
        end
        squash = 1'b1;
        in_tag = 4'd9;
        @(negedge clk);
        chk("sq_in_rdy", {62'b0, rdy64, rdy32}, 64'd0);
        cyc();
        squash = 1'b0;
        in_val = 1'b0;
        chk("sq_out_val", {62'b0, ov64, ov32}, 64'd0);
        cyc();
        chk("sq_dropped", {62'b0, ov64, ov32}, 64'd0);

        // Randomized traffic with occasional squash.
        repeat (400) begin
            in_val  = ($urandom_range(0, 3) != 0);
            out_rdy = ($urandom_range(0, 2) != 0);
            squash  = ($urandom_range(0, 31) == 0);
            in_inst = $urandom;
            in_type = 3'($urandom_range(0, 7));
            in_tag  = 4'($urandom);
            cyc();
        end
        squash  = 1'b0;
        in_val  = 1'b0;
        out_rdy = 1'b1;
        repeat (5) cyc();
        chk("rand_drain32", 64'(q32.size()), 64'd0);
        chk("rand_drain64", 64'(q64.size()), 64'd0);

        // Asynchronous reset between edges while holding an entry.
        out_rdy = 1'b0;
        in_val  = 1'b1;
        in_inst = 32'hFFF00093;
        in_type = 3'd0;
        cyc();
        cyc();
        chk("pre_rst_val", {63'b0, ov32}, 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_val", {62'b0, ov64, ov32}, 64'd0);
        chk("async_rst_imm", oi64 | {32'b0, oi32}, 64'd0);
        chk("async_rst_rdy", {62'b0, rdy64, rdy32}, 64'd0);
        in_val = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
